node_bcast: RTL and testbench

NODE_BCAST -- requirements
Module: node_bcast

---
 rtl/node_bcast.sv | 136 +++++++++++++
 tb/tb_node_bcast.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/node_bcast.sv
// Broadcasts a latched node value to up to four enabled neighbors in turn.
// It collects each neighbor's response and flags any neighbor that never acknowledges.
module node_bcast #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] val_in,
    input  logic [3:0] en_mask,
    input  logic [3:0] tx_ack,
    input  logic       resp_in,
    output logic       tx_valid,
    output logic [1:0] tx_sel,
    output logic [1:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       result,
    output logic [3:0] resp_vec,
    output logic [3:0] err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [1:0] val_q, val_n;
    logic [3:0] mask_q, mask_n;
    logic [7:0] wait_cnt, wait_n;
    logic [3:0] resp_q, resp_n;
    logic [3:0] err_q, err_n;
    logic       result_q, result_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            val_q    <= 2'd0;
            mask_q   <= 4'd0;
            wait_cnt <= 8'd0;
            resp_q   <= 4'd0;
            err_q    <= 4'd0;
            result_q <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            val_q    <= val_n;
            mask_q   <= mask_n;
            wait_cnt <= wait_n;
            resp_q   <= resp_n;
            err_q    <= err_n;
            result_q <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        val_n    = val_q;
        mask_n   = mask_q;
        wait_n   = wait_cnt;
        resp_n   = resp_q;
        err_n    = err_q;
        result_n = result_q;

        case (state)
            IDLE: begin
                if (load) begin
                    val_n    = val_in;
                    mask_n   = en_mask;
                    resp_n   = 4'd0;
                    err_n    = 4'd0;
                    result_n = 1'b0;
                    idx_n    = 2'd0;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (mask_q[idx]) begin
                    wait_n  = 8'd0;
                    state_n = SEND;
                end else if (idx == 2'd3) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx + 2'd1;
                end
            end
            SEND: begin
                // An ack in the final wait cycle takes priority over the timeout.
                if (tx_ack[idx] || wait_cnt == WAIT_LIMIT) begin
                    if (tx_ack[idx]) begin
                        resp_n[idx] = resp_in;
                    end else begin
                        err_n[idx] = 1'b1;
                    end
                    if (idx == 2'd3) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = SCAN;
                    end
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Result is computed on entry so it is already valid alongside the done pulse.
        if (state_n == DONE && state != DONE) begin
            result_n = |resp_n;
        end
    end

    assign tx_valid = (state == SEND);
    assign tx_sel   = tx_valid ? idx : 2'd0;
    assign tx_data  = tx_valid ? val_q : 2'd0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign result   = result_q;
    assign resp_vec = resp_q;
    assign err      = err_q;

endmodule

// File: tb/tb_node_bcast.sv
// Scoreboard bench for node_bcast: directed broadcasts with an emulated neighbor responder.
module tb_node_bcast;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [1:0] val_in;
    logic [3:0] en_mask;
    logic [3:0] tx_ack;
    logic       resp_in;
    logic       tx_valid;
    logic [1:0] tx_sel;
    logic [1:0] tx_data;
    logic       busy;
    logic       done;
    logic       result;
    logic [3:0] resp_vec;
    logic [3:0] err;

    node_bcast #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .load(load), .val_in(val_in), .en_mask(en_mask),
        .tx_ack(tx_ack), .resp_in(resp_in), .tx_valid(tx_valid), .tx_sel(tx_sel),
        .tx_data(tx_data), .busy(busy), .done(done), .result(result),
        .resp_vec(resp_vec), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       result;
        logic [3:0] resp_vec;
        logic [3:0] err;
        int         latency;
        int         valids;
        logic [3:0] seen;
        logic [1:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_count = 0;

    int         ack_delay [4];
    logic [3:0] resp_bits;
    logic       stray;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Neighbor model: each neighbor acks after a programmed number of SEND cycles.
    int   resp_wait = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [3:0] a;
        a = 4'd0;
        if (tx_valid) begin
            resp_wait = prev_valid ? resp_wait + 1 : 0;
            if (stray) a = ~(4'b0001 << tx_sel);
            if (resp_wait == ack_delay[tx_sel]) a[tx_sel] = 1'b1;
            resp_in = resp_bits[tx_sel];
        end else begin
            resp_in = 1'b0;
        end
        tx_ack     = a;
        prev_valid = tx_valid;
    end

    int         busy_cnt = 0;
    int         valid_cnt = 0;
    logic [3:0] seen = 4'd0;
    int         data_bad = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_cnt  = 0;
            valid_cnt = 0;
            seen      = 4'd0;
            data_bad  = 0;
        end else begin
            if (busy) busy_cnt++;
            if (tx_valid) begin
                valid_cnt++;
                seen[tx_sel] = 1'b1;
                if (sb.size() > 0 && tx_data !== sb[0].data) data_bad++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result",   int'(result),   int'(e.result));
                    checkOutput("resp_vec", int'(resp_vec), int'(e.resp_vec));
                    checkOutput("err",      int'(err),      int'(e.err));
                    checkOutput("latency",  busy_cnt,       e.latency);
                    checkOutput("tx_valid_cycles", valid_cnt, e.valids);
                    checkOutput("tx_sel_visited", int'(seen), int'(e.seen));
                    checkOutput("tx_data_errors", data_bad, 0);
                end
                busy_cnt  = 0;
                valid_cnt = 0;
                seen      = 4'd0;
                data_bad  = 0;
                done_count++;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] v, input logic [3:0] m,
                                 input int d0, input int d1, input int d2, input int d3,
                                 input logic [3:0] rb, input logic st, input exp_t e);
        ack_delay[0] = d0;
        ack_delay[1] = d1;
        ack_delay[2] = d2;
        ack_delay[3] = d3;
        resp_bits    = rb;
        stray        = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        val_in  = v;
        en_mask = m;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int start;
        bit hit;
        start = done_count;
        hit   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_count > start) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) checkOutput("done_timeout", 0, 1);
        #1;
    endtask

    function automatic exp_t mk(input logic r, input logic [3:0] rv, input logic [3:0] er,
                                input int lat, input int nv, input logic [3:0] sn,
                                input logic [1:0] d);
        exp_t e;
        e.result = r; e.resp_vec = rv; e.err = er; e.latency = lat;
        e.valids = nv; e.seen = sn; e.data = d;
        return e;
    endfunction

    initial begin
        bit hit;
        rst = 1'b0; load = 1'b0; val_in = 2'd0; en_mask = 4'd0;
        tx_ack = 4'd0; resp_in = 1'b0; stray = 1'b0; resp_bits = 4'd0;
        for (int i = 0; i < 4; i++) ack_delay[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_tx_valid", int'(tx_valid), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_outputs", int'({result, resp_vec, err, tx_sel, tx_data}), 0);
        rst = 1'b1;

        $display("[TB] all four neighbors, immediate acks");
        applyStimulus(2'b10, 4'b1111, 0, 0, 0, 0, 4'b0010, 1'b0,
                      mk(1'b1, 4'b0010, 4'b0000, 9, 4, 4'b1111, 2'b10));
        waitDone(40);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_result", int'(result), 1);
        checkOutput("hold_resp_vec", int'(resp_vec), 2);
        checkOutput("hold_err", int'(err), 0);

        $display("[TB] neighbors 0 and 2 only");
        applyStimulus(2'b01, 4'b0101, 0, 0, 0, 0, 4'b1111, 1'b0,
                      mk(1'b1, 4'b0101, 4'b0000, 7, 2, 4'b0101, 2'b01));
        waitDone(40);

        $display("[TB] neighbor 1 never acks");
        applyStimulus(2'b11, 4'b0010, 99, 99, 99, 99, 4'b1111, 1'b0,
                      mk(1'b0, 4'b0000, 4'b0010, 21, 16, 4'b0010, 2'b11));
        waitDone(60);

        $display("[TB] ack in the timeout cycle");
        applyStimulus(2'b10, 4'b0001, 15, 99, 99, 99, 4'b0001, 1'b0,
                      mk(1'b1, 4'b0001, 4'b0000, 21, 16, 4'b0001, 2'b10));
        waitDone(60);

        $display("[TB] stray acks on non-selected lines");
        applyStimulus(2'b01, 4'b1000, 99, 99, 99, 2, 4'b1000, 1'b1,
                      mk(1'b1, 4'b1000, 4'b0000, 8, 3, 4'b1000, 2'b01));
        waitDone(40);

        $display("[TB] empty mask");
        applyStimulus(2'b11, 4'b0000, 0, 0, 0, 0, 4'b1111, 1'b0,
                      mk(1'b0, 4'b0000, 4'b0000, 5, 0, 4'b0000, 2'b11));
        waitDone(40);

        $display("[TB] load while busy is ignored");
        applyStimulus(2'b01, 4'b0011, 0, 0, 0, 0, 4'b0001, 1'b0,
                      mk(1'b1, 4'b0001, 4'b0000, 7, 2, 4'b0011, 2'b01));
        @(posedge clk);
        #1;
        val_in = 2'b11; en_mask = 4'b1111; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        waitDone(40);

        $display("[TB] reset during SEND of neighbor 2");
        stray = 1'b0;
        for (int i = 0; i < 4; i++) ack_delay[i] = 99;
        @(posedge clk);
        #1;
        val_in = 2'b11; en_mask = 4'b0100; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid && tx_sel == 2'd2) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("reached_send2", int'(hit), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_tx_valid", int'(tx_valid), 0);
        checkOutput("midrst_outputs", int'({done, result, resp_vec, err, tx_sel, tx_data}), 0);
        repeat (25) @(posedge clk);
        #1;
        checkOutput("no_resume_busy", int'(busy), 0);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
